mips_fetch_stage: RTL

Instruction fetch stage sitting directly upstream of the MIPS word-addressed memory's instruction read port. It owns the program counter, issues one-cycle-latency reads to the memory, buffers returned words in a 2-entry skid FIFO, and presents them to decode over a valid/ready handshake. It also handles branch redirects, flushing any work from the wrong path, and flags out-of-range fetches.

---
 rtl/mips_fetch_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mips_fetch_stage.sv
// Instruction fetch: PC, one-cycle memory read, 2-entry skid FIFO, redirect flush, range fault.
// Define MIPS_FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module mips_fetch_stage #(
   parameter int          MEM_DEPTH = 32,
   parameter logic [31:0] RESET_PC  = 32'd0
) (
   input  logic        MIPS_fetch_clk,
   input  logic        MIPS_fetch_rst,
   input  logic        fetch_enable,
   output logic        MIPS_read,
   output logic [31:0] while_read_instruction_MIPS_address,
   input  logic [31:0] while_read_instruction_MIPS_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   output logic        fetch_fault,
   output logic [1:0]  fetch_state
`ifdef MIPS_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   // Handshake: an instruction moves to decode on a clock edge where instr_valid && instr_ready,
   // except in a redirect cycle, where the FIFO is flushed and that pop is discarded.
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;

   localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

   state_t      state, state_next;
   logic [31:0] pc;
   logic        inflight;
   logic [31:0] inflight_pc;
   logic [31:0] fifo_data [2];
   logic [31:0] fifo_pc   [2];
   logic        rd_ptr, wr_ptr;
   logic [1:0]  count;
   logic        pop, fifo_pop, push, issue;
   logic [2:0]  occ;
   logic        pc_in_range, target_in_range;

   assign pc_in_range     = pc < DEPTH;
   assign target_in_range = redirect_pc < DEPTH;
   assign instr_valid     = count != 2'd0;
   assign instr_data      = fifo_data[rd_ptr];
   assign instr_pc        = fifo_pc[rd_ptr];
   assign pop             = instr_valid && instr_ready;
   assign fifo_pop        = pop && !redirect_valid;
   // The returning word of a read is dropped if a redirect lands in its return cycle.
   assign push            = inflight && !redirect_valid;
   assign while_read_instruction_MIPS_address = pc;
   assign fetch_state     = state;

   always_ff @(posedge MIPS_fetch_clk or posedge MIPS_fetch_rst) begin
      if (MIPS_fetch_rst) state <= ST_IDLE;
      else                state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (fetch_enable) state_next = ST_RUN;
         ST_RUN: begin
            if (!fetch_enable)                        state_next = ST_IDLE;
            else if (!pc_in_range && !redirect_valid) state_next = ST_HALT;
         end
         ST_HALT: begin
            if (redirect_valid)
               state_next = (target_in_range && fetch_enable) ? ST_RUN : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Credit counts buffered words plus the one in flight, so the FIFO can never overflow.
   always_comb begin
      occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      issue     = (state == ST_RUN) && pc_in_range && !redirect_valid && (occ < 3'd2);
      MIPS_read = issue;
   end

   always_ff @(posedge MIPS_fetch_clk or posedge MIPS_fetch_rst) begin
      if (MIPS_fetch_rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'd0;
         fetch_fault <= 1'b0;
      end else if (redirect_valid) begin
         pc          <= redirect_pc;
         inflight    <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc          <= pc + 32'd1;
            inflight_pc <= pc;
         end
         if (state == ST_RUN && state_next == ST_HALT) fetch_fault <= 1'b1;
      end
   end

   always_ff @(posedge MIPS_fetch_clk or posedge MIPS_fetch_rst) begin
      if (MIPS_fetch_rst) begin
         count        <= 2'd0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         fifo_data[0] <= 32'd0;
         fifo_data[1] <= 32'd0;
         fifo_pc[0]   <= 32'd0;
         fifo_pc[1]   <= 32'd0;
      end else if (redirect_valid) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= while_read_instruction_MIPS_data;
            fifo_pc[wr_ptr]   <= inflight_pc;
            wr_ptr            <= ~wr_ptr;
         end
         if (fifo_pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, fifo_pop};
      end
   end

   push_into_full_a: assert property (@(posedge MIPS_fetch_clk) disable iff (MIPS_fetch_rst)
      !(push && count == 2'd2 && !fifo_pop));

`ifdef MIPS_FETCH_PERF_EN
   always_ff @(posedge MIPS_fetch_clk or posedge MIPS_fetch_rst) begin
      if (MIPS_fetch_rst) begin
         perf_fetched <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         if (pop)                        perf_fetched <= perf_fetched + 32'd1;
         if (instr_valid && !instr_ready) perf_stall  <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
